adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 11 +
 rtl/adder_arbiter_if.sv | 28 ++
 rtl/four_bit_adder.sv | 16 +
 rtl/adder_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter: FSM encoding,
// operand width and default counter width.
package adder_pkg;
   localparam int OPW       = 4;
   localparam int CNT_W_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;
endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the arbiter.
interface adder_arbiter_if import adder_pkg::*; ();
   logic           req0_valid;
   logic           req1_valid;
   logic [OPW-1:0] req0_a;
   logic [OPW-1:0] req0_b;
   logic [OPW-1:0] req1_a;
   logic [OPW-1:0] req1_b;
   logic           req0_ready;
   logic           req1_ready;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [OPW-1:0] rsp_sum;
   logic           rsp_ovf;
   logic           rsp_cout;
   logic           rsp_id;

   // master: requesters plus result consumer; slave: the arbiter itself
   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_ovf, rsp_cout, rsp_id
   );

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_sum, rsp_ovf, rsp_cout, rsp_id
   );
endinterface

// File: rtl/four_bit_adder.sv
// Combinational 4-bit adder reporting signed overflow and unsigned carry-out.
module four_bit_adder import adder_pkg::*; (
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   output logic [OPW-1:0] sum,
   output logic           ovf,
   output logic           cout
);
   logic [OPW:0] full;

   assign full = {1'b0, a} + {1'b0, b};
   assign sum  = full[OPW-1:0];
   assign cout = full[OPW];
   // Same-sign operands whose sum flips sign cannot be represented.
   assign ovf  = (a[OPW-1] == b[OPW-1]) && (sum[OPW-1] != a[OPW-1]);
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 4-bit adder between two requesters, with
// per-requester saturating overflow counters.
module adder_arbiter import adder_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   adder_arbiter_if.slave   bus,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] ovf_cnt0,
   output logic [CNT_W-1:0] ovf_cnt1
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t         state_reg, state_next;
   logic [OPW-1:0] a_reg, b_reg;
   logic           id_reg;
   logic           last_reg;
   logic           gnt0, gnt1;
   logic           accept;
   logic           rsp_fire;
   logic [OPW-1:0] sum;
   logic           ovf, cout;
   logic [CNT_W-1:0] cnt_reg [2];

   always_comb begin
      state_next = state_reg;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      case (state_reg)
         IDLE: begin
            // On a tie the requester that did not win last time goes next.
            if (bus.req0_valid && bus.req1_valid) begin
               gnt0 = last_reg;
               gnt1 = !last_reg;
            end else begin
               gnt0 = bus.req0_valid;
               gnt1 = bus.req1_valid;
            end
            if (gnt0 || gnt1) state_next = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept         = gnt0 || gnt1;
   assign rsp_fire       = (state_reg == RESP) && bus.rsp_ready;
   assign bus.req0_ready = gnt0 && rst_n;
   assign bus.req1_ready = gnt1 && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         id_reg    <= 1'b0;
         last_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_reg    <= gnt1 ? bus.req1_a : bus.req0_a;
            b_reg    <= gnt1 ? bus.req1_b : bus.req0_b;
            id_reg   <= gnt1;
            last_reg <= gnt1;
         end
      end
   end

   four_bit_adder u_add (
      .a    (a_reg),
      .b    (b_reg),
      .sum  (sum),
      .ovf  (ovf),
      .cout (cout)
   );

   assign bus.rsp_valid = (state_reg == RESP);
   assign bus.rsp_sum   = sum;
   assign bus.rsp_ovf   = ovf;
   assign bus.rsp_cout  = cout;
   assign bus.rsp_id    = id_reg;

   // Clear wins over a coincident increment; counters stick at all-ones.
   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_reg[gi] <= '0;
         end else if (clr_cnt) begin
            cnt_reg[gi] <= '0;
         end else if (rsp_fire && ovf && (id_reg == 1'(gi)) && (cnt_reg[gi] != CNT_MAX)) begin
            cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
         end
      end
   end

   assign ovf_cnt0 = cnt_reg[0];
   assign ovf_cnt1 = cnt_reg[1];
endmodule
